// File: rtl/peripheral_bus_master.sv
// Initiator end of the internal peripheral bus: turns single Wishbone classic cycles
// into one-cycle write strobes or timed read strobes, returning ack or timeout error.
module peripheral_bus_master #(
   parameter int unsigned ADDRESS_WIDTH = 24,
   parameter int unsigned TIMEOUT       = 8,
   parameter logic [31:0] TIMEOUT_DATA  = 32'hDEADBEEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wb_cyc_i,
   input  logic                     wb_stb_i,
   input  logic                     wb_we_i,
   input  logic [3:0]               wb_sel_i,
   input  logic [ADDRESS_WIDTH-1:0] wb_adr_i,
   input  logic [31:0]              wb_data_i,
   output logic                     wb_ack_o,
   output logic                     wb_error_o,
   output logic [31:0]              wb_data_o,
   output logic                     peripheralBus_we,
   output logic                     peripheralBus_oe,
   output logic [ADDRESS_WIDTH-1:0] peripheralBus_address,
   output logic [3:0]               peripheralBus_byteSelect,
   output logic [31:0]              peripheralBus_dataWrite,
   input  logic [31:0]              peripheralBus_dataRead,
   input  logic                     requestOutput
);

   localparam int unsigned CountWidth = $clog2(TIMEOUT);
   localparam logic [CountWidth-1:0] LastCount = CountWidth'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      stIdle,
      stWrite,
      stRead,
      stAck,
      stError
   } busState_e;

   busState_e               state;
   busState_e               nextState;
   logic [CountWidth-1:0]   timeoutCount;
   logic [CountWidth-1:0]   countNxt;
   logic                    weNxt;
   logic                    oeNxt;
   logic                    ackNxt;
   logic                    errorNxt;
   logic [ADDRESS_WIDTH-1:0] addressNxt;
   logic [3:0]              byteSelectNxt;
   logic [31:0]             dataWriteNxt;
   logic [31:0]             dataReadNxt;

   // State, counter and every output are registered together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                    <= stIdle;
         timeoutCount             <= '0;
         wb_ack_o                 <= 1'b0;
         wb_error_o               <= 1'b0;
         wb_data_o                <= '0;
         peripheralBus_we         <= 1'b0;
         peripheralBus_oe         <= 1'b0;
         peripheralBus_address    <= '0;
         peripheralBus_byteSelect <= '0;
         peripheralBus_dataWrite  <= '0;
      end else begin
         state                    <= nextState;
         timeoutCount             <= countNxt;
         wb_ack_o                 <= ackNxt;
         wb_error_o               <= errorNxt;
         wb_data_o                <= dataReadNxt;
         peripheralBus_we         <= weNxt;
         peripheralBus_oe         <= oeNxt;
         peripheralBus_address    <= addressNxt;
         peripheralBus_byteSelect <= byteSelectNxt;
         peripheralBus_dataWrite  <= dataWriteNxt;
      end
   end

   // Dropping wb_cyc_i aborts any active state; a responder answer beats the timeout
   always_comb begin
      nextState = state;
      case (state)
         stIdle: begin
            if (wb_cyc_i && wb_stb_i) begin
               nextState = wb_we_i ? stWrite : stRead;
            end
         end
         stWrite: nextState = wb_cyc_i ? stAck : stIdle;
         stRead: begin
            if (!wb_cyc_i) begin
               nextState = stIdle;
            end else if (requestOutput) begin
               nextState = stAck;
            end else if (timeoutCount == LastCount) begin
               nextState = stError;
            end
         end
         stAck:   nextState = stIdle;
         stError: nextState = stIdle;
         default: nextState = stIdle;
      endcase
   end

   // Next output values follow the state being entered, so strobes appear with the state
   always_comb begin
      weNxt         = (nextState == stWrite);
      oeNxt         = (nextState == stRead);
      ackNxt        = (nextState == stAck);
      errorNxt      = (nextState == stError);
      addressNxt    = peripheralBus_address;
      byteSelectNxt = '0;
      dataWriteNxt  = '0;
      dataReadNxt   = wb_data_o;
      countNxt      = '0;

      if (state == stIdle && nextState != stIdle) begin
         addressNxt    = wb_adr_i;
         byteSelectNxt = wb_sel_i;
      end else if (state == stRead && nextState == stRead) begin
         byteSelectNxt = peripheralBus_byteSelect;
         countNxt      = timeoutCount + CountWidth'(1);
      end

      if (nextState == stWrite) begin
         dataWriteNxt = wb_data_i;
      end

      if (state == stRead && nextState == stAck) begin
         dataReadNxt = peripheralBus_dataRead;
      end else if (nextState == stError) begin
         dataReadNxt = TIMEOUT_DATA;
      end
   end

endmodule

// File: tb/tb_peripheral_bus_master.sv
// Bench for peripheral_bus_master: directed and random Wishbone transfers checked
// against a per-transfer model of strobe counts, ack/error outcome and read data.
module tb_peripheral_bus_master;

   localparam int unsigned Aw      = 24;
   localparam int          Timeout = 8;
   localparam logic [31:0] ToData  = 32'hDEADBEEF;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wb_cyc_i = 1'b0;
   logic          wb_stb_i = 1'b0;
   logic          wb_we_i = 1'b0;
   logic [3:0]    wb_sel_i = '0;
   logic [Aw-1:0] wb_adr_i = '0;
   logic [31:0]   wb_data_i = '0;
   logic          wb_ack_o;
   logic          wb_error_o;
   logic [31:0]   wb_data_o;
   logic          peripheralBus_we;
   logic          peripheralBus_oe;
   logic [Aw-1:0] peripheralBus_address;
   logic [3:0]    peripheralBus_byteSelect;
   logic [31:0]   peripheralBus_dataWrite;
   logic [31:0]   peripheralBus_dataRead = '0;
   logic          requestOutput = 1'b0;

   int            checks = 0;
   int            failures = 0;
   logic [31:0]   expData = '0;

   peripheral_bus_master #(
      .ADDRESS_WIDTH(Aw),
      .TIMEOUT(Timeout),
      .TIMEOUT_DATA(ToData)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .wb_cyc_i(wb_cyc_i),
      .wb_stb_i(wb_stb_i),
      .wb_we_i(wb_we_i),
      .wb_sel_i(wb_sel_i),
      .wb_adr_i(wb_adr_i),
      .wb_data_i(wb_data_i),
      .wb_ack_o(wb_ack_o),
      .wb_error_o(wb_error_o),
      .wb_data_o(wb_data_o),
      .peripheralBus_we(peripheralBus_we),
      .peripheralBus_oe(peripheralBus_oe),
      .peripheralBus_address(peripheralBus_address),
      .peripheralBus_byteSelect(peripheralBus_byteSelect),
      .peripheralBus_dataWrite(peripheralBus_dataWrite),
      .peripheralBus_dataRead(peripheralBus_dataRead),
      .requestOutput(requestOutput)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, ".ack"}, 32'(wb_ack_o), 32'd0);
      check({tag, ".error"}, 32'(wb_error_o), 32'd0);
      check({tag, ".data"}, wb_data_o, 32'd0);
      check({tag, ".we"}, 32'(peripheralBus_we), 32'd0);
      check({tag, ".oe"}, 32'(peripheralBus_oe), 32'd0);
      check({tag, ".address"}, 32'(peripheralBus_address), 32'd0);
      check({tag, ".byteSelect"}, 32'(peripheralBus_byteSelect), 32'd0);
      check({tag, ".dataWrite"}, peripheralBus_dataWrite, 32'd0);
   endtask

   // lat: oe cycle on which the responder answers (0 = never); abortAt: oe cycle on which cyc drops
   task automatic runXfer(input logic isWrite, input logic [Aw-1:0] adr, input logic [3:0] sel,
                          input logic [31:0] data, input logic [31:0] rdData,
                          input int lat, input int abortAt);
      int weCnt;
      int oeCnt;
      int ackCnt;
      int errCnt;
      int ackCyc;
      int errCyc;
      int firstStrobe;
      int endAt;
      int expStrobe;
      bit expAck;
      bit expErr;
      weCnt = 0; oeCnt = 0; ackCnt = 0; errCnt = 0;
      ackCyc = -1; errCyc = -1; firstStrobe = -1; endAt = -1;

      if (isWrite) begin
         expStrobe = 1; expAck = 1'b1; expErr = 1'b0;
      end else if (abortAt > 0) begin
         expStrobe = abortAt; expAck = 1'b0; expErr = 1'b0;
      end else if (lat >= 1 && lat <= Timeout) begin
         expStrobe = lat; expAck = 1'b1; expErr = 1'b0; expData = rdData;
      end else begin
         expStrobe = Timeout; expAck = 1'b0; expErr = 1'b1; expData = ToData;
      end

      @(negedge clk);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = isWrite;
      wb_adr_i = adr; wb_sel_i = sel; wb_data_i = data;
      requestOutput = 1'b0;

      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         check("address", 32'(peripheralBus_address), 32'(adr));
         check("strobeExclusive", 32'(peripheralBus_we & peripheralBus_oe), 32'd0);
         check("termWithStrobe", 32'((wb_ack_o | wb_error_o) & (peripheralBus_we | peripheralBus_oe)), 32'd0);
         if (peripheralBus_we || peripheralBus_oe) begin
            if (firstStrobe < 0) firstStrobe = c;
            check("byteSelect", 32'(peripheralBus_byteSelect), 32'(sel));
         end else begin
            check("idleByteSelect", 32'(peripheralBus_byteSelect), 32'd0);
            check("idleDataWrite", peripheralBus_dataWrite, 32'd0);
         end
         if (peripheralBus_we) begin
            weCnt++;
            check("dataWrite", peripheralBus_dataWrite, data);
         end
         if (peripheralBus_oe) begin
            oeCnt++;
            check("readDataWrite", peripheralBus_dataWrite, 32'd0);
         end
         if (wb_ack_o) begin
            ackCnt++; ackCyc = c;
            check("ackData", wb_data_o, expData);
         end
         if (wb_error_o) begin
            errCnt++; errCyc = c;
            check("errorData", wb_data_o, expData);
         end

         // Responder: answers on the chosen oe cycle, noise on the bus otherwise
         if (peripheralBus_oe && oeCnt == lat) begin
            requestOutput = 1'b1; peripheralBus_dataRead = rdData;
         end else if (peripheralBus_oe) begin
            requestOutput = 1'b0; peripheralBus_dataRead = $urandom;
         end else begin
            requestOutput = 1'($urandom_range(0, 1)); peripheralBus_dataRead = $urandom;
         end

         if (wb_ack_o || wb_error_o || (abortAt != 0 && peripheralBus_oe && oeCnt == abortAt)) begin
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            if (endAt < 0) endAt = c + 3;
         end
         if (endAt >= 0 && c >= endAt) break;
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

      check("finished", 32'(endAt >= 0), 32'd1);
      check("firstStrobe", 32'(firstStrobe), 32'd0);
      check("strobeCount", 32'(isWrite ? weCnt : oeCnt), 32'(expStrobe));
      check("wrongStrobe", 32'(isWrite ? oeCnt : weCnt), 32'd0);
      check("ackCount", 32'(ackCnt), 32'(expAck));
      check("errorCount", 32'(errCnt), 32'(expErr));
      if (expAck) check("ackCycle", 32'(ackCyc), 32'(expStrobe));
      if (expErr) check("errorCycle", 32'(errCyc), 32'(expStrobe));
      check("dataHold", wb_data_o, expData);
   endtask

   initial begin
      #12;
      checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed scenarios
      runXfer(1'b1, 24'h000104, 4'b0011, 32'hA5A5_1234, 32'h0, 0, 0);
      runXfer(1'b0, 24'h000200, 4'b1111, 32'h0, 32'h0000_00FF, 2, 0);
      runXfer(1'b0, 24'h000300, 4'b1111, 32'h0, 32'h1234_5678, 0, 0);
      runXfer(1'b0, 24'h000304, 4'b0101, 32'h0, 32'hCAFE_F00D, 8, 0);
      runXfer(1'b0, 24'h000308, 4'b1111, 32'h0, 32'h0, 0, 3);
      runXfer(1'b0, 24'h00030C, 4'b1100, 32'h0, 32'h0BAD_C0DE, 1, 0);
      runXfer(1'b1, 24'h000400, 4'b0000, 32'h5555_AAAA, 32'h0, 0, 0);
      runXfer(1'b0, 24'h000404, 4'b1111, 32'h0, 32'h7777_8888, 9, 0);

      // Asynchronous reset in the middle of a read
      @(negedge clk);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
      wb_adr_i = 24'h000500; wb_sel_i = 4'hF;
      requestOutput = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("preResetOe", 32'(peripheralBus_oe), 32'd1);
      rst_n = 1'b0;
      #1;
      checkAllZero("midReadReset");
      expData = '0;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      runXfer(1'b1, 24'h000104, 4'b0011, 32'hA5A5_1234, 32'h0, 0, 0);

      // Random traffic
      for (int i = 0; i < 30; i++) begin
         runXfer(1'($urandom_range(0, 1)), Aw'($urandom), 4'($urandom_range(0, 15)),
                 $urandom, $urandom, int'($urandom_range(0, 10)), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
